// File: rtl/sd_seq_pkg.sv
// Shared types and constants for the SD command sequencer.
package sd_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_CMD0_WR,
    S_CMD7_WR,
    S_RD_WR,
    S_WAIT,
    S_CLR,
    S_READY,
    S_ERROR
  } state_t;

  // Which command is in flight; selects where CLR goes next.
  typedef enum logic [1:0] {
    K_CMD0,
    K_CMD7,
    K_READ
  } cmd_kind_t;

  localparam logic [6:0] REG_ARG0   = 7'd0;
  localparam logic [6:0] REG_ARG1   = 7'd1;
  localparam logic [6:0] REG_ARG2   = 7'd2;
  localparam logic [6:0] REG_ARG3   = 7'd3;
  localparam logic [6:0] REG_FLAGS  = 7'd4;
  localparam logic [6:0] REG_CMD    = 7'd5;
  localparam logic [6:0] REG_BLKCNT = 7'h48;

  localparam logic [7:0] CMD_GO_IDLE     = 8'd0;
  localparam logic [7:0] CMD_SELECT      = 8'd7;
  localparam logic [7:0] CMD_READ_SINGLE = 8'd17;
  localparam logic [7:0] CMD_READ_MULTI  = 8'd18;

  typedef struct packed {
    logic [3:0]      count;
    logic [7:0][6:0] addrs;
    logic [7:0][7:0] datas;
  } wr_list_t;

  // Builds the ordered register-write list for one command; the argument
  // LSB write is always last because it triggers the command.
  function automatic wr_list_t build_list(input logic        with_cnt,
                                          input logic [7:0]  blkcnt,
                                          input logic [7:0]  cmd_idx,
                                          input logic [7:0]  flags,
                                          input logic [31:0] arg);
    wr_list_t l;
    l = '0;
    l.addrs[0] = REG_BLKCNT; l.datas[0] = blkcnt;
    l.addrs[1] = REG_CMD;    l.datas[1] = cmd_idx;
    l.addrs[2] = REG_FLAGS;  l.datas[2] = flags;
    l.addrs[3] = REG_ARG3;   l.datas[3] = arg[31:24];
    l.addrs[4] = REG_ARG2;   l.datas[4] = arg[23:16];
    l.addrs[5] = REG_ARG1;   l.datas[5] = arg[15:8];
    l.addrs[6] = REG_ARG0;   l.datas[6] = arg[7:0];
    l.count    = 4'd7;
    // Commands without a block count drop entry 0 by shifting the list down.
    if (!with_cnt) begin
      l.addrs = l.addrs >> 7;
      l.datas = l.datas >> 8;
      l.count = 4'd6;
    end
    return l;
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_writer.sv
// Serialises a loaded list of (addr, data) pairs into one-cycle register writes.
module sd_reg_writer (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [3:0]      count,
  input  logic [7:0][6:0] addrs,
  input  logic [7:0][7:0] datas,
  output logic            we,
  output logic [6:0]      addr,
  output logic [7:0]      wdata,
  output logic            last
);

  logic [7:0][6:0] addr_q;
  logic [7:0][7:0] data_q;
  logic [2:0]      idx;
  logic [3:0]      remain;

  // The first pair is emitted on the load edge so writes start the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      idx    <= '0;
      remain <= '0;
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      last   <= 1'b0;
    end else if (load) begin
      addr_q <= addrs;
      data_q <= datas;
      we     <= 1'b1;
      addr   <= addrs[0];
      wdata  <= datas[0];
      idx    <= 3'd1;
      remain <= count - 4'd1;
      last   <= (count == 4'd1);
    end else if (remain != 4'd0) begin
      we     <= 1'b1;
      addr   <= addr_q[idx];
      wdata  <= data_q[idx];
      idx    <= idx + 3'd1;
      remain <= remain - 4'd1;
      last   <= (remain == 4'd1);
    end else begin
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      last   <= 1'b0;
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Drives sdc_controller through CMD0/CMD7 bring-up, then CMD17/CMD18 block reads.
module sd_cmd_sequencer
  import sd_seq_pkg::*;
#(
  parameter logic [15:0] RCA         = 16'h0013,
  parameter logic [7:0]  FLAGS_CMD0  = 8'h00,
  parameter logic [7:0]  FLAGS_CMD7  = 8'h00,
  parameter logic [7:0]  FLAGS_READ  = 8'b0011_1101,
  parameter logic [6:0]  STATUS_ADDR = 7'h0C,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_lba,
  input  logic [7:0]  req_nblocks,
  output logic        init_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  input  logic [7:0]  reg_rdata
);

  state_t    state;
  cmd_kind_t kind;

  logic        wr_load;
  wr_list_t    wr_list;
  logic        wr_we;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_wdata;
  logic        wr_last;

  logic        poll_on;
  logic        poll_valid;
  logic        clr_we;
  logic [7:0]  gap_cnt;
  logic [15:0] tcnt;
  logic [7:0]  eff_cnt;
  logic        unused_status;

  assign unused_status = ^reg_rdata[7:2];

  sd_reg_writer u_writer (
    .clk   (clk),
    .rst   (rst),
    .load  (wr_load),
    .count (wr_list.count),
    .addrs (wr_list.addrs),
    .datas (wr_list.datas),
    .we    (wr_we),
    .addr  (wr_addr),
    .wdata (wr_wdata),
    .last  (wr_last)
  );

  // Selects the write list to load on entry to each write state.
  always_comb begin
    eff_cnt = (req_nblocks == 8'd0) ? 8'd1 : req_nblocks;
    wr_load = 1'b0;
    wr_list = build_list(1'b0, 8'd0, CMD_GO_IDLE, FLAGS_CMD0, 32'd0);
    case (state)
      S_RESET: wr_load = 1'b1;
      S_CLR: begin
        if (kind == K_CMD0) begin
          wr_load = 1'b1;
          wr_list = build_list(1'b0, 8'd0, CMD_SELECT, FLAGS_CMD7, {RCA, 16'h0000});
        end
      end
      S_READY: begin
        if (req_valid) begin
          wr_load = 1'b1;
          wr_list = build_list(1'b1, eff_cnt,
                               (eff_cnt == 8'd1) ? CMD_READ_SINGLE : CMD_READ_MULTI,
                               FLAGS_READ, req_lba);
        end
      end
      default: ;
    endcase
  end

  // Bus is the OR of mutually exclusive sources, each zero when idle.
  assign reg_we    = wr_we | clr_we;
  assign reg_addr  = wr_addr | ((poll_on | clr_we) ? STATUS_ADDR : 7'd0);
  assign reg_wdata = wr_wdata;

  // Main sequencing FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RESET;
      kind       <= K_CMD0;
      req_ready  <= 1'b0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      poll_on    <= 1'b0;
      poll_valid <= 1'b0;
      clr_we     <= 1'b0;
      gap_cnt    <= '0;
      tcnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_RESET: begin
          busy  <= 1'b1;
          kind  <= K_CMD0;
          state <= S_CMD0_WR;
        end
        S_CMD0_WR, S_CMD7_WR, S_RD_WR: begin
          if (wr_last) begin
            state   <= S_WAIT;
            gap_cnt <= '0;
            tcnt    <= '0;
          end
        end
        S_WAIT: begin
          if (!poll_on) begin
            if (gap_cnt == 8'(POLL_GAP - 1)) begin
              poll_on <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end else begin
            // Read data trails the status address by one cycle.
            poll_valid <= 1'b1;
            if (poll_valid) begin
              if (reg_rdata[1] || (!reg_rdata[0] && tcnt == 16'(TIMEOUT - 1))) begin
                poll_on    <= 1'b0;
                poll_valid <= 1'b0;
                err        <= 1'b1;
                busy       <= 1'b0;
                state      <= S_ERROR;
              end else if (reg_rdata[0]) begin
                poll_on    <= 1'b0;
                poll_valid <= 1'b0;
                clr_we     <= 1'b1;
                state      <= S_CLR;
              end else begin
                tcnt <= tcnt + 16'd1;
              end
            end
          end
        end
        S_CLR: begin
          clr_we <= 1'b0;
          if (kind == K_CMD0) begin
            kind  <= K_CMD7;
            state <= S_CMD7_WR;
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            init_done <= 1'b1;
            done      <= (kind == K_READ);
            state     <= S_READY;
          end
        end
        S_READY: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            kind      <= K_READ;
            state     <= S_RD_WR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench: fake sdc_controller status register plus a write-list model.
module tb_sd_cmd_sequencer;

  localparam int POLL_GAP = 8;
  localparam int TIMEOUT  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_lba = '0;
  logic [7:0]  req_nblocks = '0;
  logic        init_done, busy, done, err;
  logic [6:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic [7:0]  reg_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [14:0] gotq[$];
  logic [14:0] expq[$];
  int          done_cnt = 0;
  logic        ready_at_done = 1'b0;

  int          resp_delay = 50;
  logic [7:0]  resp_value = 8'h01;
  logic [7:0]  status;
  logic        pend;
  int          dly;

  sd_cmd_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_lba     (req_lba),
    .req_nblocks (req_nblocks),
    .init_done   (init_done),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_rdata   (reg_rdata)
  );

  always #5 clk = ~clk;

  // Fake controller: status appears resp_delay cycles after the trigger write.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      status    <= 8'h00;
      pend      <= 1'b0;
      dly       <= 0;
      reg_rdata <= 8'h00;
    end else begin
      if (reg_we && reg_addr == 7'h00) begin
        pend <= 1'b1;
        dly  <= resp_delay;
      end else if (pend) begin
        if (dly == 0) begin
          status <= resp_value;
          pend   <= 1'b0;
        end else begin
          dly <= dly - 1;
        end
      end
      if (reg_we && reg_addr == 7'h0C) status <= 8'h00;
      reg_rdata <= (reg_addr == 7'h0C) ? status : 8'h00;
    end
  end

  // Bus monitor on the inactive edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we) gotq.push_back({reg_addr, reg_wdata});
      if (done) begin
        done_cnt++;
        ready_at_done = req_ready;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Model: one command is its ordered register writes followed by the status clear.
  task automatic push_cmd(input bit with_cnt, input logic [7:0] blk, input logic [7:0] idx,
                          input logic [7:0] flags, input logic [31:0] arg);
    if (with_cnt) expq.push_back({7'h48, blk});
    expq.push_back({7'd5, idx});
    expq.push_back({7'd4, flags});
    expq.push_back({7'd3, arg[31:24]});
    expq.push_back({7'd2, arg[23:16]});
    expq.push_back({7'd1, arg[15:8]});
    expq.push_back({7'd0, arg[7:0]});
    expq.push_back({7'h0C, 8'h00});
  endtask

  task automatic compare_writes(input string tag);
    check($sformatf("%s_nwr", tag), gotq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < gotq.size()) check($sformatf("%s_wr%0d", tag, i), 32'(gotq[i]), 32'(expq[i]));
    end
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    gotq.delete();
    done_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic run_init(input string tag);
    expq.delete();
    push_cmd(1'b0, 8'd0, 8'd0, 8'h00, 32'h0);
    push_cmd(1'b0, 8'd0, 8'd7, 8'h00, 32'h0013_0000);
    for (int c = 0; c < 3000 && !init_done && !err; c++) @(negedge clk);
    check({tag, "_init_done"}, init_done, 1'b1);
    check({tag, "_ready_after_init"}, req_ready, 1'b1);
    check({tag, "_busy_after_init"}, busy, 1'b0);
    check({tag, "_no_done_in_init"}, done_cnt, 0);
    compare_writes(tag);
  endtask

  task automatic run_read(input string tag, input logic [31:0] lba, input logic [7:0] nb);
    logic [7:0] eff;
    eff = (nb == 8'd0) ? 8'd1 : nb;
    expq.delete();
    push_cmd(1'b1, eff, (eff == 8'd1) ? 8'd17 : 8'd18, 8'h3D, lba);
    gotq.delete();
    done_cnt = 0;
    req_lba = lba;
    req_nblocks = nb;
    req_valid = 1'b1;
    for (int c = 0; c < 50 && !req_ready; c++) @(negedge clk);
    check({tag, "_ready_before"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_lba = $urandom;
    req_nblocks = 8'($urandom);
    check({tag, "_first_wr"}, reg_we, 1'b1);
    check({tag, "_ready_drop"}, req_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    for (int c = 0; c < 3000 && done_cnt == 0 && !err; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_ready_with_done"}, ready_at_done, 1'b1);
    check({tag, "_no_err"}, err, 1'b0);
    compare_writes(tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_we", reg_we, 1'b0);
    check("rst_addr", reg_addr, 7'd0);
    check("rst_wdata", reg_wdata, 8'd0);
    check("rst_ready", req_ready, 1'b0);
    check("rst_init", init_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);

    // Release: busy and the first CMD0 write appear one cycle later
    resp_delay = 50;
    resp_value = 8'h01;
    rst = 1'b0;
    @(negedge clk);
    check("rel_busy", busy, 1'b1);
    check("rel_first_we", reg_we, 1'b1);
    check("rel_first_addr", reg_addr, 7'd5);
    run_init("init");

    // Directed and random reads
    run_read("rd_1234", 32'h0000_1234, 8'd1);
    resp_delay = 3;
    run_read("rd_n8", $urandom, 8'd8);
    resp_delay = 0;
    run_read("rd_n0", $urandom, 8'd0);
    for (int k = 0; k < 6; k++) begin
      resp_delay = $urandom_range(0, 40);
      run_read($sformatf("rd_rand%0d", k), $urandom, 8'($urandom_range(0, 255)));
    end

    // Error status: both bits set, error wins, no done
    resp_value = 8'h03;
    resp_delay = 10;
    gotq.delete();
    done_cnt = 0;
    req_lba = 32'hA5A5_0001;
    req_nblocks = 8'd4;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 500 && !err; c++) @(negedge clk);
    check("st3_err", err, 1'b1);
    check("st3_busy", busy, 1'b0);
    check("st3_ready", req_ready, 1'b0);
    req_valid = 1'b1;
    repeat (20) @(negedge clk);
    req_valid = 1'b0;
    check("st3_no_done", done_cnt, 0);
    check("st3_ready_hold", req_ready, 1'b0);
    check("st3_err_hold", err, 1'b1);
    check("st3_writes", gotq.size(), 7);

    // Timeout: status never sets
    resp_value = 8'h01;
    resp_delay = 20;
    apply_reset();
    run_init("init2");
    resp_value = 8'h00;
    req_lba = 32'h0000_0042;
    req_nblocks = 8'd2;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !(reg_we && reg_addr == 7'd0); c++) @(negedge clk);
    check("to_trigger_seen", {reg_we, reg_addr}, {1'b1, 7'd0});
    repeat (POLL_GAP + TIMEOUT - 1) @(negedge clk);
    check("to_not_early", err, 1'b0);
    repeat (5) @(negedge clk);
    check("to_err", err, 1'b1);
    check("to_ready", req_ready, 1'b0);
    check("to_busy", busy, 1'b0);

    // Reset in the middle of a read write burst
    resp_value = 8'h01;
    resp_delay = 15;
    apply_reset();
    run_init("init3");
    req_lba = 32'h1111_2222;
    req_nblocks = 8'd3;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_we_before", reg_we, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_we", reg_we, 1'b0);
    check("mid_addr", reg_addr, 7'd0);
    check("mid_wdata", reg_wdata, 8'd0);
    check("mid_busy", busy, 1'b0);
    check("mid_init", init_done, 1'b0);
    repeat (2) @(negedge clk);
    gotq.delete();
    done_cnt = 0;
    rst = 1'b0;
    run_init("reinit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
